// File: rtl/shiftaes_block_packer.sv
// shiftaes_block_packer
//   Packs a byte stream big-endian into 64-bit plaintext blocks for the
//   ShiftAES core. It pads the final block of each message and hands each
//   block downstream over a valid/ready handshake.
//
//   Build option: SHIFTAES_PKCS_PAD_EN
//     defined   - PKCS#7 padding (pad byte = 8-k). A message that ends on a
//                 full block is followed by a pad-only block.
//     undefined - zero padding. A full final block carries out_last itself.
//
//   Ports
//     clk, reset          rising-edge clock, async active-high reset
//     in_data/in_valid/   byte input with valid/ready handshake;
//     in_last/in_ready    in_last marks the final byte of a message
//     out_block/out_valid block output with valid/ready handshake;
//     out_ready           the first byte of a block is in [63:56]
//     out_last            block is the final block of a message
//     out_nbytes          number of real message bytes in out_block (0..8)
//     blk_cnt             blocks handed off since reset (wraps)
//
//   state | meaning
//   ------+------------------------------------------------------------
//   FILL  | assembling bytes; in_ready=1
//   HOLD  | data block in output register, waiting for handshake
//   PAD   | pad-only block in output register, waiting for handshake

module shiftaes_block_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [63:0] out_block,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic [3:0]  out_nbytes,
  output logic [15:0] blk_cnt
);

  typedef enum logic [1:0] {ST_FILL, ST_HOLD, ST_PAD} state_t;

  localparam logic [63:0] PAD_BLOCK = {8{8'h08}};

  state_t      state_q, state_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [63:0] asm_q, asm_d;
  logic [63:0] out_block_q, out_block_d;
  logic        out_last_q, out_last_d;
  logic [3:0]  out_nbytes_q, out_nbytes_d;
  logic [15:0] blk_cnt_q, blk_cnt_d;
  logic        pend_pad_q, pend_pad_d;

  logic        in_fire;
  logic        out_fire;
  logic        blk_done;
  logic [7:0]  pad_byte;
  logic [63:0] fill_block;

  assign in_ready   = (state_q == ST_FILL);
  assign out_valid  = (state_q != ST_FILL);
  assign in_fire    = in_valid & in_ready;
  assign out_fire   = out_valid & out_ready;
  assign blk_done   = in_last | (byte_idx_q == 3'd7);

  assign out_block  = out_block_q;
  assign out_last   = out_last_q;
  assign out_nbytes = out_nbytes_q;
  assign blk_cnt    = blk_cnt_q;

`ifdef SHIFTAES_PKCS_PAD_EN
  // k = byte_idx+1 real bytes, so the pad value 8-k equals 7-byte_idx.
  assign pad_byte = 8'd7 - {5'd0, byte_idx_q};
`else
  assign pad_byte = 8'h00;
`endif

  // Block as it will look once the current byte lands: lanes below the
  // index come from the assembly register, the current lane takes in_data
  // directly, and lanes above are pad. All 8 lanes are driven, so stale
  // assembly bytes from an earlier block cannot leak out.
  always_comb begin
    fill_block = '0;
    for (int l = 0; l < 8; l++) begin
      if (3'(l) < byte_idx_q)
        fill_block[8*(7-l) +: 8] = asm_q[8*(7-l) +: 8];
      else if (3'(l) == byte_idx_q)
        fill_block[8*(7-l) +: 8] = in_data;
      else
        fill_block[8*(7-l) +: 8] = pad_byte;
    end
  end

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    asm_d        = asm_q;
    out_block_d  = out_block_q;
    out_last_d   = out_last_q;
    out_nbytes_d = out_nbytes_q;
    blk_cnt_d    = blk_cnt_q;
    pend_pad_d   = pend_pad_q;

    unique case (state_q)
      ST_FILL: begin
        if (in_fire) begin
          asm_d[8*(7-int'(byte_idx_q)) +: 8] = in_data;
          byte_idx_d = byte_idx_q + 3'd1;
          if (blk_done) begin
            out_block_d  = fill_block;
            out_nbytes_d = {1'b0, byte_idx_q} + 4'd1;
            byte_idx_d   = 3'd0;
            state_d      = ST_HOLD;
`ifdef SHIFTAES_PKCS_PAD_EN
            // A full final block still needs a pad block behind it.
            out_last_d = in_last & (byte_idx_q != 3'd7);
            pend_pad_d = in_last & (byte_idx_q == 3'd7);
`else
            out_last_d = in_last;
`endif
          end
        end
      end
      ST_HOLD: begin
        if (out_fire) begin
          blk_cnt_d = blk_cnt_q + 16'd1;
          if (pend_pad_q) begin
            out_block_d  = PAD_BLOCK;
            out_nbytes_d = 4'd0;
            out_last_d   = 1'b1;
            state_d      = ST_PAD;
          end else begin
            state_d = ST_FILL;
          end
        end
      end
      ST_PAD: begin
        if (out_fire) begin
          blk_cnt_d  = blk_cnt_q + 16'd1;
          pend_pad_d = 1'b0;
          state_d    = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_FILL;
      byte_idx_q   <= 3'd0;
      asm_q        <= '0;
      out_block_q  <= '0;
      out_last_q   <= 1'b0;
      out_nbytes_q <= 4'd0;
      blk_cnt_q    <= 16'd0;
      pend_pad_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      asm_q        <= asm_d;
      out_block_q  <= out_block_d;
      out_last_q   <= out_last_d;
      out_nbytes_q <= out_nbytes_d;
      blk_cnt_q    <= blk_cnt_d;
      pend_pad_q   <= pend_pad_d;
    end
  end

endmodule

// File: tb/tb_shiftaes_block_packer.sv
`timescale 1ns/1ps
module tb_shiftaes_block_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [63:0] out_block;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [3:0]  out_nbytes;
  logic [15:0] blk_cnt;

  always #5 clk = ~clk;

  shiftaes_block_packer dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .out_block  (out_block),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .out_nbytes (out_nbytes),
    .blk_cnt    (blk_cnt)
  );

`ifdef SHIFTAES_PKCS_PAD_EN
  localparam logic [63:0] EXP3  = 64'h1122330505050505;
  localparam logic [63:0] EXPAB = 64'hAABB060606060606;
  localparam int          NB8   = 2;
  localparam int          NB16  = 3;
  localparam logic        L8    = 1'b0;
`else
  localparam logic [63:0] EXP3  = 64'h1122330000000000;
  localparam logic [63:0] EXPAB = 64'hAABB000000000000;
  localparam int          NB8   = 1;
  localparam int          NB16  = 2;
  localparam logic        L8    = 1'b1;
`endif

  typedef struct {
    logic [63:0] blk;
    logic        last;
    logic [3:0]  nb;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] tx_q[$];
  logic [7:0] msg[$];
  int         hs_cyc[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         hs_count = 0;
  int         cyc = 0;
  int         acc_cnt = 0;
  int         exp_cnt = 0;
  int         vprob = 100;
  int         rprob = 100;
  logic       acc = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] pad_of(input int k);
`ifdef SHIFTAES_PKCS_PAD_EN
    return 8'(8 - k);
`else
    return 8'h00;
`endif
  endfunction

  // Reference: chop the message into 8-byte chunks, pad the short tail,
  // and add a pad-only block when PKCS padding meets an exact multiple of 8.
  task automatic commit_msg();
    int   n;
    int   k;
    exp_t e;
    n = msg.size();
    for (int i = 0; i < n; i++) tx_q.push_back({(i == n - 1), msg[i]});
    for (int base = 0; base < n; base += 8) begin
      k = (n - base >= 8) ? 8 : n - base;
      e.blk = '0;
      for (int l = 0; l < 8; l++)
        e.blk[8*(7-l) +: 8] = (l < k) ? msg[base + l] : pad_of(k);
      e.nb   = 4'(k);
      e.last = (base + 8 >= n);
`ifdef SHIFTAES_PKCS_PAD_EN
      if (k == 8) e.last = 1'b0;
`endif
      exp_q.push_back(e);
    end
`ifdef SHIFTAES_PKCS_PAD_EN
    if (n % 8 == 0) begin
      e.blk = 64'h0808080808080808; e.last = 1'b1; e.nb = 4'd0;
      exp_q.push_back(e);
    end
`endif
    msg.delete();
  endtask

  task automatic drive();
    in_valid = (tx_q.size() > 0) && ($urandom_range(0, 99) < vprob);
    if (tx_q.size() > 0) {in_last, in_data} = tx_q[0];
    else begin
      in_data = 8'($urandom);
      in_last = 1'($urandom_range(0, 1));
    end
    out_ready = ($urandom_range(0, 99) < rprob);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (acc) begin
      void'(tx_q.pop_front());
      acc_cnt++;
    end
    drive();
  endtask

  task automatic drain(input int maxc);
    int c = 0;
    while ((tx_q.size() > 0 || exp_q.size() > 0) && c < maxc) begin
      step();
      c++;
    end
    if (c >= maxc) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: %0d blocks still pending after %0d cycles", exp_q.size(), c);
    end
    repeat (2) step();
  endtask

  task automatic monitor();
    logic        prev_stall;
    logic        prev_done;
    logic [63:0] pb;
    logic        pl;
    logic [3:0]  pn;
    int          pos;
    exp_t        e;
    prev_stall = 1'b0; prev_done = 1'b0; pos = 0;
    pb = '0; pl = 1'b0; pn = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        prev_stall = 1'b0; prev_done = 1'b0; pos = 0; acc = 1'b0;
      end else begin
        check("in_ready_vs_out_valid", in_ready, !out_valid);
        check("blk_cnt", blk_cnt, 16'(hs_count));
        if (prev_done) check("latency_out_valid", out_valid, 1'b1);
        if (prev_stall) begin
          check("stall_valid", out_valid, 1'b1);
          check("stall_block", out_block, pb);
          check("stall_last", out_last, pl);
          check("stall_nbytes", out_nbytes, pn);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_block: got %h with none outstanding", out_block);
          end else begin
            e = exp_q.pop_front();
            check("out_block", out_block, e.blk);
            check("out_last", out_last, e.last);
            check("out_nbytes", out_nbytes, e.nb);
          end
          hs_count++;
          hs_cyc.push_back(cyc);
        end
        acc = in_valid && in_ready;
        prev_done = 1'b0;
        if (acc) begin
          pos++;
          if (pos == 8 || in_last) begin
            prev_done = 1'b1;
            pos = 0;
          end
        end
        prev_stall = out_valid && !out_ready;
        pb = out_block; pl = out_last; pn = out_nbytes;
      end
    end
  endtask

  initial begin
    int c;
    int n;
    int start;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_block", out_block, 64'h0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_nbytes", out_nbytes, 4'd0);
    check("rst_blk_cnt", blk_cnt, 16'd0);

    // 3-byte message
    vprob = 100; rprob = 100;
    msg = '{8'h11, 8'h22, 8'h33};
    commit_msg();
    check("model_3byte_blk", exp_q[0].blk, EXP3);
    check("model_3byte_nb", exp_q[0].nb, 4'd3);
    drive();
    drain(200);
    exp_cnt += 1;
    check("blk_cnt_3byte", blk_cnt, 16'(exp_cnt));

    // 8-byte message
    for (int i = 1; i <= 8; i++) msg.push_back(8'(i));
    commit_msg();
    check("model_8byte_blk", exp_q[0].blk, 64'h0102030405060708);
    check("model_8byte_last", exp_q[0].last, L8);
    check("model_8byte_count", exp_q.size(), NB8);
    drive();
    drain(200);
    exp_cnt += NB8;
    check("blk_cnt_8byte", blk_cnt, 16'(exp_cnt));
`ifdef SHIFTAES_PKCS_PAD_EN
    n = hs_cyc.size();
    check("pad_no_gap", hs_cyc[n-1] - hs_cyc[n-2], 1);
`endif

    // 16-byte stream, first block stalled 5 cycles with input still offered
    for (int i = 1; i <= 16; i++) msg.push_back(8'(i));
    commit_msg();
    check("model_16byte_blk2", exp_q[1].blk, 64'h090A0B0C0D0E0F10);
    check("model_16byte_last2", exp_q[1].last, L8);
    rprob = 0;
    drive();
    c = 0;
    while (!out_valid && c < 50) begin step(); c++; end
    check("stall_reached_hold", out_valid, 1'b1);
    repeat (5) step();
    rprob = 100;
    drain(200);
    exp_cnt += NB16;
    check("blk_cnt_16byte", blk_cnt, 16'(exp_cnt));

    // randomized messages with random handshake pressure
    for (int b = 0; b < 4; b++) begin
      vprob = $urandom_range(30, 100);
      rprob = $urandom_range(30, 100);
      for (int m = 0; m < 15; m++) begin
        n = $urandom_range(1, 20);
        for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
        commit_msg();
      end
      drive();
      drain(8000);
    end

    // reset after 5 bytes of a message have been accepted
    vprob = 100; rprob = 100;
    for (int i = 0; i < 6; i++) msg.push_back(8'($urandom));
    commit_msg();
    start = acc_cnt;
    drive();
    c = 0;
    while (acc_cnt < start + 5 && c < 100) begin step(); c++; end
    check("reset_prefill_5_bytes", acc_cnt - start, 5);
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_block", out_block, 64'h0);
    check("midrst_out_last", out_last, 1'b0);
    check("midrst_out_nbytes", out_nbytes, 4'd0);
    check("midrst_blk_cnt", blk_cnt, 16'd0);
    tx_q.delete();
    exp_q.delete();
    hs_cyc.delete();
    hs_count = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("postrst_in_ready", in_ready, 1'b1);
    msg = '{8'hAA, 8'hBB};
    commit_msg();
    check("model_aabb_blk", exp_q[0].blk, EXPAB);
    drive();
    drain(200);
    check("blk_cnt_after_reset", blk_cnt, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/shiftaes_block_packer.md
# shiftaes_block_packer

Upstream stage of the ShiftAES encryption core: accepts a byte stream over a valid/ready handshake, packs bytes big-endian into 64-bit plaintext blocks, pads the final block of each message, and presents each block to the encryption core over a valid/ready handshake. Buffering is limited to one assembly register and one output register, with a small FSM controlling fill, hold and the pad-only block.

## Interface
- No parameters.
- clk  input  1  clock, all logic on rising edge
- reset  input  1  asynchronous, active-high
- in_data  input  8  message byte
- in_valid  input  1  in_data/in_last valid
- in_last  input  1  final byte of message
- in_ready  output  1  packer accepts a byte this cycle
- out_block  output  64  plaintext block; first byte of block in [63:56]
- out_valid  output  1  out_block valid
- out_ready  input  1  downstream accepts block
- out_last  output  1  block is the final block of the message
- out_nbytes  output  4  real message bytes in out_block, 0..8
- blk_cnt  output  16  blocks handed off since reset, wraps 0xFFFF->0x0000

## Operation
- States: FILL (assembling), HOLD (block in output register), PAD (pad-only block in output register). Reset state FILL.
- Handshakes: a byte transfers on in_valid & in_ready; a block transfers on out_valid & out_ready. in_ready = (state == FILL). out_valid = (state != FILL).
- FILL: each accepted byte goes to lane byte_idx (lane 0 = [63:56]); byte_idx (3 bits) increments.
  - 8th byte accepted, in_last=0: load output register, out_nbytes=8, out_last=0 -> HOLD.
  - byte accepted with in_last=1, k = byte_idx+1 bytes held (1..8): fill lanes k..7 with pad byte, out_nbytes=k -> HOLD.
- HOLD: outputs stable until handshake. On handshake: blk_cnt+1; if pend_pad set -> PAD (load pad-only block), else -> FILL with byte_idx=0.
- PAD: out_block = 0x0808080808080808, out_nbytes=0, out_last=1. On handshake: blk_cnt+1, clear pend_pad -> FILL.
- in_valid/in_last while not FILL: ignored, no transfer.
- in_last with zero bytes is impossible (in_last always qualifies a real byte).
- Assembly register is not cleared between blocks; only lanes < out_nbytes and pad lanes are defined, and all 8 lanes are driven on load.
- reset mid-message or mid-HOLD: all partial bytes and the held block are discarded; pend_pad cleared.

## Timing
- Reset values: in_ready=1 (after reset deasserts), out_block=0, out_valid=0, out_last=0, out_nbytes=0, blk_cnt=0; internal byte_idx=0, pend_pad=0.
- Latency: out_valid rises the cycle after the completing byte transfer.
- Throughput: 8 byte cycles + at least 1 HOLD cycle per block (9 cycles/block with out_ready held high); no byte accepted in the cycle a block is handed off.
- Pad-only block: out_valid stays high from HOLD into PAD with no gap when out_ready=1.
- blk_cnt updates the cycle after each block handshake.

## Configuration
- SHIFTAES_PKCS_PAD_EN defined: pad byte = 8-k (PKCS#7). Message ending on a full block (k=8): that block leaves with out_last=0 and pend_pad set; the PAD block follows with out_last=1.
- SHIFTAES_PKCS_PAD_EN undefined: pad byte = 0x00; k=8 final block leaves with out_last=1; PAD state unreachable, pend_pad held 0.

## Test plan
- 3-byte message 0x11,0x22,0x33 (last on 0x33), out_ready=1 -> one block 0x1122330505050505 (PAD_EN) / 0x1122330000000000 (no PAD_EN), out_nbytes=3, out_last=1, blk_cnt=1.
- 8-byte message 0x01..0x08, PAD_EN, out_ready=1 -> 0x0102030405060708 out_last=0 nbytes=8, next cycle 0x0808080808080808 out_last=1 nbytes=0, blk_cnt=2; without PAD_EN single block out_last=1, blk_cnt=1.
- 16-byte stream, out_ready low 5 cycles on first block -> out_block/out_last/out_nbytes stable, in_ready=0 throughout, second block 0x090A0B0C0D0E0F10 correct after release.
- in_valid=1 with bytes presented during HOLD -> no byte consumed; next FILL takes the byte present when in_ready returns.
- reset asserted after 5 bytes accepted -> outputs at reset values immediately; next 2-byte message 0xAA,0xBB gives 0xAABB060606060606 (PAD_EN).
- 65536 single-byte messages -> blk_cnt wraps to 0x0000.
